// File: rtl/stage_eval_seq.sv
// Session-based stage evaluator: consumes NUM_STAGES scored beats, carries a bonus
// level between beats, accumulates saturating bad points and emits one verdict.
module stage_eval_seq #(
  parameter int W          = 3,
  parameter int NUM_STAGES = 4,
  parameter int LOW_MAX    = 3,
  parameter int HIGH_MIN   = 5,
  parameter int BAD_LIMIT  = 1,
  parameter int BAD_W      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [1:0]                          in_bonus,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0]                        in_slide,
  input  logic [W-1:0]                        in_timing,
  input  logic [W-1:0]                        in_luck,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_pass,
  output logic [$clog2(NUM_STAGES+1)-1:0]     out_passed_cnt,
  output logic [BAD_W-1:0]                    out_bad_total,
  output logic [1:0]                          out_bonus
);
  localparam int CW = $clog2(NUM_STAGES+1);
  // sum width wide enough for any bad_total plus a 3-bit beat score
  localparam int SW = (BAD_W > 3 ? BAD_W : 3) + 1;
  localparam logic [W-1:0]  LM   = W'(LOW_MAX);
  localparam logic [W-1:0]  HM   = W'(HIGH_MIN);
  localparam logic [2:0]    BL   = 3'(BAD_LIMIT > 7 ? 7 : BAD_LIMIT);
  localparam logic [SW-1:0] BMAX = SW'((1 << BAD_W) - 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   passed_cnt;
  logic [BAD_W-1:0] bad_total;
  logic [1:0]      bonus;
  logic            alive;

  logic [W-1:0]  sx, tx;
  logic          hard, a_sl, a_sh, a_tl, a_th, bflg, pass;
  logic [2:0]    bad;
  logic [SW-1:0] bsum;
  logic [1:0]    bonus_nx;

  // XOR patterns compare against zero-extended constants, so widen both sides
  always_comb begin
    sx       = in_slide ^ in_luck;
    tx       = in_timing ^ in_luck;
    hard     = (in_slide == '0) || (in_timing == '0);
    a_sl     = (in_slide <= LM) && (32'(sx) == 32'd0) && (bonus != 2'd3);
    a_sh     = (in_slide >= HM) && (32'(sx) == 32'd1);
    a_tl     = (in_timing <= LM) && (32'(tx) == 32'd2) && (bonus == 2'd0);
    a_th     = (in_timing > LM) && (32'(tx) == 32'd4) && (bonus < 2'd2);
    bad      = 3'({a_sl, 1'b0}) + 3'(a_sh) + 3'({a_tl, 1'b0}) + 3'(a_th);
    bflg     = (in_slide >= HM) && !a_sh;
    pass     = !hard && ((bad <= BL) || bflg);
    bsum     = SW'(bad_total) + SW'(bad);
    bonus_nx = (pass && bflg && bonus != 2'd3) ? bonus + 2'd1 : bonus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      passed_cnt <= '0;
      bad_total  <= '0;
      bonus      <= '0;
      alive      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          bonus      <= in_bonus;
          beat_cnt   <= '0;
          passed_cnt <= '0;
          bad_total  <= '0;
          alive      <= 1'b1;
        end
        RUN: if (abort) begin
          state      <= IDLE;
          beat_cnt   <= '0;
          passed_cnt <= '0;
          bad_total  <= '0;
          bonus      <= '0;
          alive      <= 1'b0;
        end else if (in_valid) begin
          passed_cnt <= passed_cnt + CW'(pass);
          bad_total  <= (bsum > BMAX) ? {BAD_W{1'b1}} : bsum[BAD_W-1:0];
          bonus      <= bonus_nx;
          alive      <= alive & pass;
          beat_cnt   <= beat_cnt + CW'(1);
          if (beat_cnt == LAST) state <= DONE;
        end
        DONE: if (abort) begin
          state      <= IDLE;
          beat_cnt   <= '0;
          passed_cnt <= '0;
          bad_total  <= '0;
          bonus      <= '0;
          alive      <= 1'b0;
        end else if (out_ready) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state == RUN);
  assign out_valid      = (state == DONE);
  assign out_pass       = alive;
  assign out_passed_cnt = passed_cnt;
  assign out_bad_total  = bad_total;
  assign out_bonus      = bonus;
endmodule

// File: tb/tb_stage_eval_seq.sv
// Drives a default instance and a narrow (BAD_W=2) instance with identical stimulus
// and checks both against a rule-level session model.
module tb_stage_eval_seq;
  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic [1:0] in_bonus;
  logic [2:0] in_slide, in_timing, in_luck;

  logic       rdy0, ov0, op0, rdy1, ov1, op1;
  logic [2:0] pc0, pc1;
  logic [3:0] bt0;
  logic [1:0] bt1, bo0, bo1;

  always #5 clk = ~clk;

  stage_eval_seq u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_bonus(in_bonus),
    .in_valid(in_valid), .in_ready(rdy0), .in_slide(in_slide), .in_timing(in_timing),
    .in_luck(in_luck), .out_valid(ov0), .out_ready(out_ready), .out_pass(op0),
    .out_passed_cnt(pc0), .out_bad_total(bt0), .out_bonus(bo0));

  stage_eval_seq #(.BAD_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_bonus(in_bonus),
    .in_valid(in_valid), .in_ready(rdy1), .in_slide(in_slide), .in_timing(in_timing),
    .in_luck(in_luck), .out_valid(ov1), .out_ready(out_ready), .out_pass(op1),
    .out_passed_cnt(pc1), .out_bad_total(bt1), .out_bonus(bo1));

  int checks = 0;
  int errors = 0;

  // session model
  int m_pc, m_bt0, m_bt1, m_b;
  bit m_alive;
  int tsl[NS], ttm[NS], tlk[NS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void beat_eval(input int s, input int t, input int x, input int b,
                                    output int bad, output bit pass, output int nb);
    bit hard, bflg, sh;
    hard = (s == 0) || (t == 0);
    sh   = (s >= 5) && ((s ^ x) == 1);
    bad  = 0;
    if (s <= 3 && (s ^ x) == 0 && b != 3) bad += 2;
    if (sh) bad += 1;
    if (t <= 3 && (t ^ x) == 2 && b == 0) bad += 2;
    if (t > 3 && (t ^ x) == 4 && b < 2) bad += 1;
    bflg = (s >= 5) && !sh;
    pass = !hard && (bad <= 1 || bflg);
    nb   = (pass && bflg) ? ((b + 1 > 3) ? 3 : b + 1) : b;
  endfunction

  task automatic model_beat(input int s, input int t, input int x);
    int bad, nb;
    bit pass;
    beat_eval(s, t, x, m_b, bad, pass, nb);
    m_pc    += int'(pass);
    m_bt0    = (m_bt0 + bad > 15) ? 15 : m_bt0 + bad;
    m_bt1    = (m_bt1 + bad > 3) ? 3 : m_bt1 + bad;
    m_b      = nb;
    m_alive  = m_alive & pass;
  endtask

  task automatic chk_verdict(input string tag);
    chk({tag, ".valid0"}, ov0, 1);
    chk({tag, ".valid1"}, ov1, 1);
    chk({tag, ".pass0"},  op0, m_alive);
    chk({tag, ".pass1"},  op1, m_alive);
    chk({tag, ".cnt0"},   pc0, m_pc);
    chk({tag, ".cnt1"},   pc1, m_pc);
    chk({tag, ".bad0"},   bt0, m_bt0);
    chk({tag, ".bad1"},   bt1, m_bt1);
    chk({tag, ".bonus0"}, bo0, m_b);
    chk({tag, ".bonus1"}, bo1, m_b);
  endtask

  // One full session from IDLE using tsl/ttm/tlk; stray start pulses mid-session
  // must be ignored. Ends either with an acknowledge or with an abort in DONE.
  task automatic run_session(input string tag, input int b0, input int stall,
                             input bit abort_done);
    @(negedge clk);
    start = 1'b1; abort = 1'($urandom_range(0, 1)); in_bonus = 2'(b0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk({tag, ".ready"}, rdy0, 1);
    m_pc = 0; m_bt0 = 0; m_bt1 = 0; m_b = b0; m_alive = 1'b1;
    for (int i = 0; i < NS; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_slide = 3'($urandom); in_timing = 3'($urandom); in_luck = 3'($urandom);
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_slide  = 3'(tsl[i]); in_timing = 3'(ttm[i]); in_luck = 3'(tlk[i]);
      start     = 1'($urandom_range(0, 1));
      in_bonus  = 2'($urandom);
      model_beat(tsl[i], ttm[i], tlk[i]);
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
    end
    chk({tag, ".ready_done"}, rdy0, 0);
    chk_verdict(tag);
    out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk_verdict({tag, ".hold"});
    end
    if (abort_done) begin
      abort = 1'b1; out_ready = 1'b1;
    end else begin
      out_ready = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk({tag, ".drop0"}, ov0, 0);
    chk({tag, ".drop1"}, ov1, 0);
    if (abort_done) chk({tag, ".abort_cnt"}, pc0, 0);
  endtask

  task automatic set_clean();
    for (int i = 0; i < NS; i++) begin
      tsl[i] = 4; ttm[i] = 4; tlk[i] = 7;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_bonus = 2'd0; in_slide = 3'd0; in_timing = 3'd0; in_luck = 3'd0;
    #12;
    chk("rst.ready", rdy0, 0);
    chk("rst.valid", ov0, 0);
    chk("rst.pass",  op0, 0);
    chk("rst.cnt",   pc0, 0);
    chk("rst.bad",   bt0, 0);
    chk("rst.bonus", bo0, 0);
    @(negedge clk);
    rst = 1'b0;

    // beats offered in IDLE are not accepted
    in_valid = 1'b1; in_slide = 3'd5; in_timing = 3'd3; in_luck = 3'd4;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("idle.ready", rdy0, 0);
    chk("idle.cnt",   pc0, 0);
    chk("idle.bad",   bt0, 0);

    // T1: aSH beat, passes, bonus unchanged
    set_clean();
    tsl[0] = 5; ttm[0] = 3; tlk[0] = 4;
    run_session("t1", 0, 1, 1'b0);

    // T2: aSL+aTL fail on first beat
    set_clean();
    tsl[0] = 3; ttm[0] = 1; tlk[0] = 3;
    run_session("t2", 0, 0, 1'b0);

    // T3 + T4: bonus climbs via bflg, verdict held for 5 cycles
    for (int i = 0; i < NS; i++) begin
      tsl[i] = 6; ttm[i] = 4; tlk[i] = 0;
    end
    run_session("t3", 0, 5, 1'b0);

    // T5: abort after two beats, taking priority over a same-cycle beat
    @(negedge clk);
    start = 1'b1; in_bonus = 2'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_slide = 3'd4; in_timing = 3'd4; in_luck = 3'd7;
    repeat (2) @(negedge clk);
    chk("t5.cnt_before", pc0, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("t5.ready", rdy0, 0);
    chk("t5.cnt",   pc0, 0);
    repeat (6) @(negedge clk);
    chk("t5.novalid", ov0, 0);

    // async reset mid-RUN clears outputs before the next clock edge
    start = 1'b1; in_bonus = 2'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("arst.cnt_before", pc0, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst.ready", rdy0, 0);
    chk("arst.cnt",   pc0, 0);
    chk("arst.bonus", bo0, 0);
    chk("arst.pass",  op0, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized sessions, luck biased towards the special XOR patterns
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NS; i++) begin
        int k;
        tsl[i] = $urandom_range(0, 7);
        ttm[i] = $urandom_range(0, 7);
        case ($urandom_range(0, 4))
          0: k = 0;
          1: k = 1;
          2: k = 2;
          3: k = 4;
          default: k = $urandom_range(0, 7);
        endcase
        tlk[i] = (($urandom_range(0, 1) != 0) ? tsl[i] : ttm[i]) ^ k;
      end
      run_session("rnd", $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
